// File: rtl/pwm_pkg.sv
// Shared widths and phase arithmetic for the multiphase PWM generator.
// Pure package: no state, no latency, no flow control.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;
  localparam int PW_W      = 32;

  // Local count of a phase-shifted channel, one conditional subtract (ph < per).
  function automatic logic [PW_W:0] phase_wrap(
    input logic [PW_W-1:0] cnt,
    input logic [PW_W-1:0] ph,
    input logic [PW_W-1:0] per
  );
    logic [PW_W:0] lc;
    lc = {1'b0, cnt} + {1'b0, ph};
    if (lc >= {1'b0, per}) begin
      lc = lc - {1'b0, per};
    end
    return lc;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel complementary gate pair; 1-cycle registered, rising edges delayed by dead.
// Deadtime logic only with MULTIPHASE_PWM_DEADTIME_EN; no backpressure.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dead,
  output logic            hi,
  output logic            lo
);

  logic cond_hi;
  logic cond_lo;

  assign cond_hi = en & raw;
  assign cond_lo = en & ~raw;

`ifdef MULTIPHASE_PWM_DEADTIME_EN
  logic [DT_W-1:0] cnt_hi;
  logic [DT_W-1:0] cnt_lo;

  // Once a side is on it stays on until its condition drops, even if dead grows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi <= '0;
      cnt_lo <= '0;
      hi     <= 1'b0;
      lo     <= 1'b0;
    end else begin
      if (!cond_hi) begin
        cnt_hi <= '0;
        hi     <= 1'b0;
      end else if (hi || cnt_hi >= dead) begin
        hi <= 1'b1;
      end else begin
        cnt_hi <= cnt_hi + DT_W'(1);
      end

      if (!cond_lo) begin
        cnt_lo <= '0;
        lo     <= 1'b0;
      end else if (lo || cnt_lo >= dead) begin
        lo <= 1'b1;
      end else begin
        cnt_lo <= cnt_lo + DT_W'(1);
      end
    end
  end
`else
  logic unused_dead;
  assign unused_dead = ^dead;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 1'b0;
      lo <= 1'b0;
    end else begin
      hi <= cond_hi;
      lo <= cond_lo;
    end
  end
`endif

endmodule

// File: rtl/multiphase_pwm.sv
// N_CH phase-shifted complementary PWM from one period counter; shadowed config applied at wrap.
// Gates and sync lag cnt by 1 cycle; no backpressure; deadtime via MULTIPHASE_PWM_DEADTIME_EN.
module multiphase_pwm
  import pwm_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [CNT_W-1:0]      period,
  input  logic [N_CH*CNT_W-1:0] duty,
  input  logic [N_CH*CNT_W-1:0] phase,
  input  logic [DT_W-1:0]       dead,
  output logic [N_CH-1:0]       gate_hi,
  output logic [N_CH-1:0]       gate_lo,
  output logic                  sync,
  output logic                  pending
);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      period_a, period_s;
  logic [N_CH*CNT_W-1:0] duty_a, duty_s;
  logic [N_CH*CNT_W-1:0] phase_a, phase_s;
  logic [DT_W-1:0]       dead_a, dead_s;

  logic             per_ok;
  logic             run;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] per_m1;
  logic [N_CH-1:0]  raw;

  assign per_ok = period_a >= CNT_W'(2);
  assign run    = en & per_ok;
  assign per_m1 = period_a - CNT_W'(1);
  assign wrap   = run && (cnt == per_m1);
  // With no live period to finish, a pending shadow takes effect immediately.
  assign apply  = pending && (wrap || !per_ok || !en);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      period_a <= '0;
      period_s <= '0;
      duty_a   <= '0;
      duty_s   <= '0;
      phase_a  <= '0;
      phase_s  <= '0;
      dead_a   <= '0;
      dead_s   <= '0;
      pending  <= 1'b0;
      sync     <= 1'b0;
    end else begin
      if (load) begin
        period_s <= period;
        duty_s   <= duty;
        phase_s  <= phase;
        dead_s   <= dead;
      end
      if (apply) begin
        period_a <= period_s;
        duty_a   <= duty_s;
        phase_a  <= phase_s;
        dead_a   <= dead_s;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (!run || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      sync <= run && (cnt == '0);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] duty_g;
    logic [CNT_W-1:0] phase_g;
    logic [CNT_W-1:0] ph;
    logic [PW_W:0]    lc;

    assign duty_g  = duty_a[g*CNT_W +: CNT_W];
    assign phase_g = phase_a[g*CNT_W +: CNT_W];
    assign ph      = (phase_g > per_m1) ? per_m1 : phase_g;
    assign lc      = phase_wrap(PW_W'(cnt), PW_W'(ph), PW_W'(period_a));
    assign raw[g]  = lc < (PW_W+1)'(duty_g);

    pwm_deadtime #(
      .DT_W(DT_W)
    ) u_dt (
      .clk  (clk),
      .rst  (rst),
      .en   (run),
      .raw  (raw[g]),
      .dead (dead_a),
      .hi   (gate_hi[g]),
      .lo   (gate_lo[g])
    );
  end

endmodule

// File: tb/tb_multiphase_pwm.sv
// Scoreboard bench for multiphase_pwm: expected gate/sync/pending per cycle from closed-form waveforms.
// Deadtime scenario selected by MULTIPHASE_PWM_DEADTIME_EN.
module tb_multiphase_pwm;

  localparam int CW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          load;
  logic [CW-1:0] period;
  logic [2*CW-1:0] duty;
  logic [2*CW-1:0] phase;
  logic [DW-1:0] dead;
  logic [1:0]    gate_hi;
  logic [1:0]    gate_lo;
  logic          sync;
  logic          pending;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [1:0] hi;
    logic [1:0] lo;
    logic       sync;
    logic       pend;
  } exp_t;

  exp_t sb[$];

  multiphase_pwm #(.N_CH(2), .CNT_W(CW), .DT_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .period  (period),
    .duty    (duty),
    .phase   (phase),
    .dead    (dead),
    .gate_hi (gate_hi),
    .gate_lo (gate_lo),
    .sync    (sync),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected raw level of a channel at output index k (k=0 is the first cnt=0 cycle).
  function automatic logic exp_raw(int k, int p, int d, int ph);
    int phc;
    phc = (ph > p - 1) ? p - 1 : ph;
    return (((k % p) + phc) % p) < d;
  endfunction

  // Disable, program, apply while idle, then enable: next step shows cnt=0.
  task automatic start(int p, int d0, int d1, int p0, int p1, int dd);
    en = 1'b0; load = 1'b0;
    step();
    period = CW'(p);
    duty   = {CW'(d1), CW'(d0)};
    phase  = {CW'(p1), CW'(p0)};
    dead   = DW'(dd);
    load   = 1'b1;
    step();
    load = 1'b0;
    step();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    period = '0; duty = '0; phase = '0; dead = '0;
    step();
    step();
    checks++; if (gate_hi !== 2'b00) $display("FAIL reset_hi got %b want 00", gate_hi); else passed++;
    checks++; if (gate_lo !== 2'b00) $display("FAIL reset_lo got %b want 00", gate_lo); else passed++;
    checks++; if (sync !== 1'b0) $display("FAIL reset_sync got %b want 0", sync); else passed++;
    checks++; if (pending !== 1'b0) $display("FAIL reset_pending got %b want 0", pending); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    start(10, 5, 5, 0, 5, 0);
    for (int k = 0; k < 30; k++) begin
      e.hi   = {exp_raw(k, 10, 5, 5), exp_raw(k, 10, 5, 0)};
      e.lo   = ~e.hi;
      e.sync = (k % 10) == 0;
      e.pend = 1'b0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi !== e.hi) $display("FAIL basic_hi k=%0d got %b want %b", k, gate_hi, e.hi); else passed++;
      checks++; if (gate_lo !== e.lo) $display("FAIL basic_lo k=%0d got %b want %b", k, gate_lo, e.lo); else passed++;
      checks++; if (sync !== e.sync) $display("FAIL basic_sync k=%0d got %b want %b", k, sync, e.sync); else passed++;
    end
  endtask

  task automatic test_shadow();
    exp_t e;
    start(10, 3, 5, 0, 5, 0);
    for (int k = 0; k < 32; k++) begin
      if (k == 14) begin
        duty = {CW'(5), CW'(7)};
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      e      = '0;
      e.hi   = {1'b0, exp_raw(k, 10, (k >= 20) ? 7 : 3, 0)};
      e.pend = (k >= 14) && (k < 19);
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi[0] !== e.hi[0]) $display("FAIL shadow_hi0 k=%0d got %b want %b", k, gate_hi[0], e.hi[0]); else passed++;
      checks++; if (pending !== e.pend) $display("FAIL shadow_pending k=%0d got %b want %b", k, pending, e.pend); else passed++;
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    start(10, 0, 5, 0, 5, 0);
    for (int k = 0; k < 45; k++) begin
      if (k == 22) begin
        duty = {CW'(5), CW'(12)};
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      e    = '0;
      e.hi = {1'b0, (k >= 30)};
      e.lo = {1'b0, (k < 30)};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi[0] !== e.hi[0]) $display("FAIL extreme_hi0 k=%0d got %b want %b", k, gate_hi[0], e.hi[0]); else passed++;
      checks++; if (gate_lo[0] !== e.lo[0]) $display("FAIL extreme_lo0 k=%0d got %b want %b", k, gate_lo[0], e.lo[0]); else passed++;
    end
  endtask

  task automatic test_enable();
    exp_t e;
    start(10, 5, 5, 0, 5, 0);
    for (int k = 0; k < 12; k++) step();
    // k=12 presents cnt=2, inside channel 0's pulse.
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = '0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi !== e.hi) $display("FAIL en_off_hi k=%0d got %b want %b", k, gate_hi, e.hi); else passed++;
      checks++; if (gate_lo !== e.lo) $display("FAIL en_off_lo k=%0d got %b want %b", k, gate_lo, e.lo); else passed++;
      checks++; if (sync !== e.sync) $display("FAIL en_off_sync k=%0d got %b want %b", k, sync, e.sync); else passed++;
    end
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      e.hi   = {exp_raw(k, 10, 5, 5), exp_raw(k, 10, 5, 0)};
      e.lo   = ~e.hi;
      e.sync = (k % 10) == 0;
      e.pend = 1'b0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi !== e.hi) $display("FAIL en_on_hi k=%0d got %b want %b", k, gate_hi, e.hi); else passed++;
      checks++; if (gate_lo !== e.lo) $display("FAIL en_on_lo k=%0d got %b want %b", k, gate_lo, e.lo); else passed++;
      checks++; if (sync !== e.sync) $display("FAIL en_on_sync k=%0d got %b want %b", k, sync, e.sync); else passed++;
    end
  endtask

`ifdef MULTIPHASE_PWM_DEADTIME_EN
  task automatic test_deadtime();
    exp_t e;
    int m;
    start(20, 10, 10, 0, 0, 3);
    for (int k = 0; k < 45; k++) begin
      m    = k % 20;
      e    = '0;
      e.hi = {1'b0, (m >= 3 && m < 10)};
      e.lo = {1'b0, (m >= 13)};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi[0] !== e.hi[0]) $display("FAIL dt3_hi0 k=%0d got %b want %b", k, gate_hi[0], e.hi[0]); else passed++;
      checks++; if (gate_lo[0] !== e.lo[0]) $display("FAIL dt3_lo0 k=%0d got %b want %b", k, gate_lo[0], e.lo[0]); else passed++;
      checks++; if ((gate_hi & gate_lo) !== 2'b00) $display("FAIL dt3_overlap k=%0d got %b want 00", k, gate_hi & gate_lo); else passed++;
    end
    start(20, 10, 10, 0, 0, 12);
    for (int k = 0; k < 45; k++) begin
      e = '0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi !== e.hi) $display("FAIL dt12_hi k=%0d got %b want %b", k, gate_hi, e.hi); else passed++;
      checks++; if (gate_lo !== e.lo) $display("FAIL dt12_lo k=%0d got %b want %b", k, gate_lo, e.lo); else passed++;
    end
  endtask
`else
  task automatic test_deadtime();
    exp_t e;
    start(20, 10, 10, 0, 0, 3);
    for (int k = 0; k < 45; k++) begin
      e    = '0;
      e.hi = {1'b0, exp_raw(k, 20, 10, 0)};
      e.lo = {1'b0, ~exp_raw(k, 20, 10, 0)};
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi[0] !== e.hi[0]) $display("FAIL nodt_hi0 k=%0d got %b want %b", k, gate_hi[0], e.hi[0]); else passed++;
      checks++; if (gate_lo[0] !== e.lo[0]) $display("FAIL nodt_lo0 k=%0d got %b want %b", k, gate_lo[0], e.lo[0]); else passed++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e;
    start(10, 5, 5, 0, 5, 0);
    for (int k = 0; k < 7; k++) step();
    load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (pending !== 1'b1) $display("FAIL rstmid_pending_set got %b want 1", pending); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (gate_hi !== 2'b00) $display("FAIL rstmid_hi got %b want 00", gate_hi); else passed++;
    checks++; if (gate_lo !== 2'b00) $display("FAIL rstmid_lo got %b want 00", gate_lo); else passed++;
    checks++; if (sync !== 1'b0) $display("FAIL rstmid_sync got %b want 0", sync); else passed++;
    checks++; if (pending !== 1'b0) $display("FAIL rstmid_pending got %b want 0", pending); else passed++;
    for (int k = 0; k < 10; k++) begin
      e = '0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi !== e.hi) $display("FAIL idle_hi k=%0d got %b want %b", k, gate_hi, e.hi); else passed++;
      checks++; if (pending !== e.pend) $display("FAIL idle_pending k=%0d got %b want %b", k, pending, e.pend); else passed++;
    end
    // Active period is 0, so the fresh load applies on the following cycle.
    load = 1'b1;
    step();
    load = 1'b0;
    checks++; if (pending !== 1'b1) $display("FAIL reload_pending_set got %b want 1", pending); else passed++;
    step();
    checks++; if (pending !== 1'b0) $display("FAIL reload_pending_clr got %b want 0", pending); else passed++;
    for (int k = 0; k < 15; k++) begin
      e      = '0;
      e.hi   = {exp_raw(k, 10, 5, 5), exp_raw(k, 10, 5, 0)};
      e.sync = (k % 10) == 0;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++; if (gate_hi !== e.hi) $display("FAIL reload_hi k=%0d got %b want %b", k, gate_hi, e.hi); else passed++;
      checks++; if (sync !== e.sync) $display("FAIL reload_sync k=%0d got %b want %b", k, sync, e.sync); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_extremes();
    test_enable();
    test_deadtime();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
